divisor_restaurador: RTL and testbench
======================================

Name: divisor_restaurador

Overview:
- Sequential signed divider; the inverse arithmetic unit to the Booth multiplier in the same datapath.
- Dividend 16-bit signed, divisor 8-bit signed. Returns a 16-bit signed quotient and an 8-bit signed remainder.
- Radix-2 restoring algorithm on magnitudes, one quotient bit per clock, sign correction in a final cycle.
- Same valid/done handshake as the multiplier, so control logic can drive both units interchangeably.

Parameters:
- ANCHO_DIVIDENDO, 16, dividend and quotient width (W); also the number of iteration cycles.
- ANCHO_DIVISOR, 8, divisor and remainder width (D); D <= W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- valid  input  1  start request; sampled only in IDLE.
- dividendo  input  W  signed dividend; captured on the accept edge.
- divisor  input  D  signed divisor; captured on the accept edge.
- cociente  output  W  signed quotient; registered.
- residuo  output  D  signed remainder; registered.
- error  output  1  divide-by-zero or overflow flag for the current result; registered.
- done  output  1  one-cycle pulse when results are valid.

Behaviour:
- Reset (async, rst=1): state=IDLE, cociente=0, residuo=0, error=0, done=0, counter=0, internal registers=0. Reset mid-operation aborts the division; no done is produced.
- States: IDLE, DIVIDE, FIX.
- IDLE:
  - valid=1 at an edge: accept the operands. Store |dividendo| in Q, |divisor| in M, clear partial remainder R (D+1 bits), store both operand signs, counter=0.
  - If divisor==0, go to FIX. Otherwise go to DIVIDE.
  - Outputs keep their previous values until FIX overwrites them.
- DIVIDE, one iteration per edge:
  - Shift {R,Q} left by 1.
  - T = R - M.
  - If T >= 0: R = T and Q[0] = 1; else Q[0] = 0 (restore).
  - counter increments. After W iterations (counter == W-1 at the edge), go to FIX.
- FIX, one edge:
  - cociente = sign_q ? -Q : Q, with sign_q = sign(dividendo) XOR sign(divisor).
  - residuo = sign(dividendo) ? -R : R. Quotient truncates toward zero; the remainder takes the dividend's sign.
  - done=1 for exactly one cycle. Return to IDLE.
- Latency:
  - Normal: done is high in the cycle after edge W+1, counting the accept edge as edge 0 (W=16: done follows edge 17).
  - Divide by zero: done follows edge 1.
- Divide by zero: error=1, residuo=0; cociente=2^(W-1)-1 if dividendo>=0, else -2^(W-1).
- Overflow (dividendo=-2^(W-1), divisor=-1): cociente=2^(W-1)-1 (saturated), residuo=0, error=1.
- All other cases: error=0.
- Width rules:
  - |dividendo| is held in W bits unsigned, so -2^(W-1) is valid.
  - |divisor| is held in D bits unsigned, so -2^(D-1) is valid.
  - Remainder magnitude is always < 2^(D-1), so it fits in D signed bits.
- valid while in DIVIDE or FIX is ignored; there is no queueing.
- valid held high continuously starts a new operation on the first IDLE edge after done. That edge coincides with the cycle in which done is high.
- done and error change only on FIX or reset. Results hold until the next FIX.

Optional Feature:
- Macro: DIVISOR_OCUPADO_EN.
- Defined: adds output port ocupado (1 bit, reset 0). It is 1 from the accept edge until the FIX edge, i.e. high during DIVIDE and FIX and low in IDLE. The external controller uses it to gate valid.
- Undefined: no ocupado port. All other behaviour is identical.

Test Plan:
- Reset during DIVIDE: assert rst at iteration 8 of 100/7 -> outputs 0 immediately, no done; a following 100/7 -> cociente=14, residuo=2.
- Sign combinations: 100/7 -> 14, 2; -100/7 -> -14, -2; 100/-7 -> -14, 2; -100/-7 -> 14, -2. Each run: error=0, done exactly 18 cycles after the accept edge, width exactly 1.
- Extremes: -32768/-128 -> 256, 0; 32767/1 -> 32767, 0; 5/127 -> 0, 5; -32768/1 -> -32768, 0.
- Error cases: 1234/0 -> 32767, 0, error=1, done after 2 cycles; -5/0 -> -32768, 0, error=1; -32768/-1 -> 32767, 0, error=1. The next valid 10/3 -> 3, 1, error=0.
- Handshake:
  - Pulse valid again during DIVIDE -> ignored, result belongs to the first operands.
  - Hold valid high -> back-to-back operations, done every 18 cycles.
  - With DIVISOR_OCUPADO_EN defined -> ocupado high for exactly 17 cycles per normal op.

Source files
------------

// File: rtl/divisor_restaurador.sv
// divisor_restaurador: sequential signed divider (restoring, radix 2).
//
// Divides a signed ANCHO_DIVIDENDO-bit dividend by a signed ANCHO_DIVISOR-bit
// divisor on operand magnitudes, one quotient bit per clock. A final FIX cycle
// applies the signs and handles the divide-by-zero and overflow cases. It uses
// the same valid/done handshake as the Booth multiplier.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active high
//   valid      start request, sampled only while idle
//   dividendo  signed dividend, captured on the accept edge
//   divisor    signed divisor, captured on the accept edge
//   cociente   signed quotient, truncated toward zero (registered)
//   residuo    signed remainder, same sign as the dividend (registered)
//   error      divide-by-zero or overflow flag for the current result
//   done       one-cycle pulse when the results are valid
//   ocupado    (only with DIVISOR_OCUPADO_EN) high from accept until FIX
//
// Optional feature macro: DIVISOR_OCUPADO_EN adds the ocupado output.

module divisor_restaurador #(
  parameter int ANCHO_DIVIDENDO = 16,
  parameter int ANCHO_DIVISOR   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid,
  input  logic [ANCHO_DIVIDENDO-1:0] dividendo,
  input  logic [ANCHO_DIVISOR-1:0]   divisor,
  output logic [ANCHO_DIVIDENDO-1:0] cociente,
  output logic [ANCHO_DIVISOR-1:0]   residuo,
  output logic                       error,
  output logic                       done
`ifdef DIVISOR_OCUPADO_EN
  ,
  output logic                       ocupado
`endif
);

  localparam int W  = ANCHO_DIVIDENDO;
  localparam int D  = ANCHO_DIVISOR;
  localparam int CW = $clog2(W);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIVIDE = 2'd1;
  localparam logic [1:0] FIX    = 2'd2;

  localparam logic [W-1:0] Q_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] Q_MIN = {1'b1, {(W-1){1'b0}}};

  logic [1:0]    estado;
  logic [W-1:0]  q;
  logic [D-1:0]  m;
  logic [D:0]    r;
  logic          signo_dvd;
  logic          signo_dvs;
  logic          div_cero;
  logic [CW-1:0] contador;

  logic [D+1:0]  resta;
  logic [D:0]    paso_r;
  logic [W-1:0]  paso_q;

  logic          signo_q;
  logic [W-1:0]  cociente_fix;
  logic [D-1:0]  residuo_fix;
  logic          error_fix;

  // One restoring step: shift {R,Q} left, try R - M, keep it if non-negative.
  // R is always below M, so the shifted value fits in D+1 bits and the
  // extra top bit of resta only carries the sign of the trial subtraction.
  always_comb begin
    resta  = {r, q[W-1]} - {2'b00, m};
    paso_q = {q[W-2:0], 1'b0};
    paso_r = {r[D-1:0], q[W-1]};
    if (!resta[D+1]) begin
      paso_r = resta[D:0];
      paso_q = {q[W-2:0], 1'b1};
    end
  end

  // Sign correction and the two saturating cases. Only -2^(W-1) / -1 can
  // produce a positive quotient magnitude with the top bit set.
  always_comb begin
    signo_q      = signo_dvd ^ signo_dvs;
    cociente_fix = signo_q ? -q : q;
    residuo_fix  = signo_dvd ? -r[D-1:0] : r[D-1:0];
    error_fix    = 1'b0;
    if (div_cero) begin
      cociente_fix = signo_dvd ? Q_MIN : Q_MAX;
      residuo_fix  = '0;
      error_fix    = 1'b1;
    end else if (!signo_q && q[W-1]) begin
      cociente_fix = Q_MAX;
      residuo_fix  = '0;
      error_fix    = 1'b1;
    end
  end

  // Control and datapath registers. valid is only looked at in IDLE, so a
  // request during DIVIDE or FIX is simply dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado    <= IDLE;
      q         <= '0;
      m         <= '0;
      r         <= '0;
      signo_dvd <= 1'b0;
      signo_dvs <= 1'b0;
      div_cero  <= 1'b0;
      contador  <= '0;
      cociente  <= '0;
      residuo   <= '0;
      error     <= 1'b0;
      done      <= 1'b0;
`ifdef DIVISOR_OCUPADO_EN
      ocupado   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (estado)
        IDLE: begin
          if (valid) begin
            q         <= dividendo[W-1] ? -dividendo : dividendo;
            m         <= divisor[D-1] ? -divisor : divisor;
            r         <= '0;
            signo_dvd <= dividendo[W-1];
            signo_dvs <= divisor[D-1];
            div_cero  <= (divisor == '0);
            contador  <= '0;
            estado    <= (divisor == '0) ? FIX : DIVIDE;
`ifdef DIVISOR_OCUPADO_EN
            ocupado   <= 1'b1;
`endif
          end
        end
        DIVIDE: begin
          q        <= paso_q;
          r        <= paso_r;
          contador <= contador + CW'(1);
          if (contador == CW'(W-1)) begin
            estado <= FIX;
          end
        end
        FIX: begin
          cociente <= cociente_fix;
          residuo  <= residuo_fix;
          error    <= error_fix;
          done     <= 1'b1;
          estado   <= IDLE;
`ifdef DIVISOR_OCUPADO_EN
          ocupado  <= 1'b0;
`endif
        end
        default: begin
          estado <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_restaurador.sv
// tb_divisor_restaurador: self-checking bench for divisor_restaurador.
// Expected results come from an integer division model and are queued when
// an operation is started; a monitor pops and compares them on every done.

module tb_divisor_restaurador;

  localparam int LAT_NORMAL = 17;
  localparam int LAT_CERO   = 1;

  typedef struct packed {
    logic [15:0] cociente;
    logic [7:0]  residuo;
    logic        error;
  } resultado_t;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [15:0] dividendo;
  logic [7:0]  divisor;
  logic [15:0] cociente;
  logic [7:0]  residuo;
  logic        error;
  logic        done;
`ifdef DIVISOR_OCUPADO_EN
  logic        ocupado;
`endif

  resultado_t sb[$];
  int n_checks;
  int n_fail;

  divisor_restaurador dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .dividendo (dividendo),
    .divisor   (divisor),
    .cociente  (cociente),
    .residuo   (residuo),
    .error     (error),
    .done      (done)
`ifdef DIVISOR_OCUPADO_EN
    ,
    .ocupado   (ocupado)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer division truncates toward zero and the
  // remainder takes the dividend's sign.
  function automatic resultado_t modelo(input int a, input int b);
    resultado_t e;
    if (b == 0) begin
      e.cociente = (a >= 0) ? 16'h7FFF : 16'h8000;
      e.residuo  = 8'h00;
      e.error    = 1'b1;
    end else if (a == -32768 && b == -1) begin
      e.cociente = 16'h7FFF;
      e.residuo  = 8'h00;
      e.error    = 1'b1;
    end else begin
      e.cociente = 16'(a / b);
      e.residuo  = 8'(a % b);
      e.error    = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard monitor: every done must match the oldest queued expectation.
  always @(negedge clk) begin
    resultado_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_done: done=1 but no operation pending");
      end else begin
        e = sb.pop_front();
        n_checks++;
        if (cociente !== e.cociente) begin
          n_fail++;
          $display("[TB] FAIL cociente: got %0d expected %0d",
                   $signed(cociente), $signed(e.cociente));
        end
        n_checks++;
        if (residuo !== e.residuo) begin
          n_fail++;
          $display("[TB] FAIL residuo: got %0d expected %0d",
                   $signed(residuo), $signed(e.residuo));
        end
        n_checks++;
        if (error !== e.error) begin
          n_fail++;
          $display("[TB] FAIL error: got %b expected %b", error, e.error);
        end
      end
    end
  end

  // Starts one operation from IDLE, checks latency and done width. If
  // pulso_k >= 0, a second request is pulsed after edge pulso_k and must be
  // ignored.
  task automatic run_op(input int a, input int b, input int lat_esp, input int pulso_k);
    int lat;
    lat = -1;
    @(negedge clk);
    valid     = 1'b1;
    dividendo = 16'(a);
    divisor   = 8'(b);
    sb.push_back(modelo(a, b));
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k - 1 == pulso_k) begin
        valid     = 1'b1;
        dividendo = 16'd50;
        divisor   = 8'd3;
      end
      @(negedge clk);
      valid = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    n_checks++;
    if (lat != lat_esp) begin
      n_fail++;
      $display("[TB] FAIL latency %0d/%0d: got %0d expected %0d", a, b, lat, lat_esp);
      if (lat < 0) sb.delete();
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL done_width %0d/%0d: done=%b expected 0", a, b, done);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    valid     = 1'b0;
    dividendo = '0;
    divisor   = '0;
    #1;
    n_checks++;
    if ({cociente, residuo, error, done} !== 26'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got %h expected 0", {cociente, residuo, error, done});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cociente, residuo, error, done} !== 26'd0) begin
      n_fail++;
      $display("[TB] FAIL idle_after_reset: got %h expected 0", {cociente, residuo, error, done});
    end
  endtask

  task automatic test_signs();
    run_op(100, 7, LAT_NORMAL, -1);
    run_op(-100, 7, LAT_NORMAL, -1);
    run_op(100, -7, LAT_NORMAL, -1);
    run_op(-100, -7, LAT_NORMAL, -1);
  endtask

  task automatic test_extremes();
    run_op(-32768, -128, LAT_NORMAL, -1);
    run_op(32767, 1, LAT_NORMAL, -1);
    run_op(5, 127, LAT_NORMAL, -1);
    run_op(-32768, 1, LAT_NORMAL, -1);
    run_op(-32768, 127, LAT_NORMAL, -1);
  endtask

  task automatic test_errors();
    run_op(1234, 0, LAT_CERO, -1);
    run_op(-5, 0, LAT_CERO, -1);
    run_op(-32768, -1, LAT_NORMAL, -1);
    run_op(10, 3, LAT_NORMAL, -1);
  endtask

  task automatic test_reset_mid();
    bit visto;
    visto = 1'b0;
    @(negedge clk);
    valid     = 1'b1;
    dividendo = 16'd100;
    divisor   = 8'd7;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({cociente, residuo, error, done} !== 26'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_outputs: got %h expected 0", {cociente, residuo, error, done});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) visto = 1'b1;
    end
    n_checks++;
    if (visto) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_no_done: done seen=%b expected 0", visto);
    end
    run_op(100, 7, LAT_NORMAL, -1);
  endtask

  task automatic test_valid_ignored();
    run_op(100, 7, LAT_NORMAL, 5);
    repeat (25) @(negedge clk);
  endtask

  // valid stays high across three operations; done must appear after edges
  // 17, 35 and 53 counting the first accept edge as 0.
  task automatic test_back_to_back();
    int posiciones[$];
    @(negedge clk);
    valid     = 1'b1;
    dividendo = 16'd1000;
    divisor   = 8'd9;
    sb.push_back(modelo(1000, 9));
    @(posedge clk);
    for (int k = 0; k <= 60; k++) begin
      @(negedge clk);
      if (done) posiciones.push_back(k);
      if (k == 0) begin
        dividendo = 16'hFC19;
        divisor   = 8'd13;
        sb.push_back(modelo(-999, 13));
      end else if (k == 18) begin
        dividendo = 16'd77;
        divisor   = 8'hF8;
        sb.push_back(modelo(77, -8));
      end else if (k == 36) begin
        valid = 1'b0;
      end
      if (k < 60) @(posedge clk);
    end
    n_checks++;
    if (posiciones.size() != 3) begin
      n_fail++;
      $display("[TB] FAIL b2b_count: got %0d dones expected 3", posiciones.size());
      sb.delete();
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (posiciones[i] != LAT_NORMAL + 18 * i) begin
          n_fail++;
          $display("[TB] FAIL b2b_timing[%0d]: got edge %0d expected %0d",
                   i, posiciones[i], LAT_NORMAL + 18 * i);
        end
      end
    end
  endtask

`ifdef DIVISOR_OCUPADO_EN
  task automatic ocupado_op(input int a, input int b, input int esperado);
    int cuenta;
    cuenta = 0;
    @(negedge clk);
    n_checks++;
    if (ocupado !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ocupado_idle: got %b expected 0", ocupado);
    end
    valid     = 1'b1;
    dividendo = 16'(a);
    divisor   = 8'(b);
    sb.push_back(modelo(a, b));
    @(posedge clk);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      valid = 1'b0;
      if (ocupado) cuenta++;
    end
    n_checks++;
    if (cuenta != esperado) begin
      n_fail++;
      $display("[TB] FAIL ocupado_cycles %0d/%0d: got %0d expected %0d", a, b, cuenta, esperado);
    end
  endtask

  task automatic test_ocupado();
    ocupado_op(100, 7, 17);
    ocupado_op(42, 0, 1);
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_signs();
    test_extremes();
    test_errors();
    test_reset_mid();
    test_valid_ignored();
    test_back_to_back();
`ifdef DIVISOR_OCUPADO_EN
    test_ocupado();
`endif
    repeat (5) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: %0d results pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
